// File: rtl/fetch_mem_arbiter.sv
// rtl/fetch_mem_arbiter.sv - round-robin arbiter sharing one memory port between icache refill and PTW
module fetch_mem_arbiter #(
    parameter int XLEN   = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ic_req_i,
    input  logic [XLEN-1:0]   ic_addr_i,
    input  logic              ic_kill_i,
    output logic              ic_ack_o,
    output logic [DATA_W-1:0] ic_rdata_o,
    input  logic              ptw_req_i,
    input  logic [XLEN-1:0]   ptw_addr_i,
    output logic              ptw_ack_o,
    output logic [DATA_W-1:0] ptw_rdata_o,
    output logic              mem_req_o,
    output logic [XLEN-1:0]   mem_addr_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              busy_o
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SERVE_IC  = 2'd1,
        SERVE_PTW = 2'd2,
        DRAIN     = 2'd3
    } state_t;

    // rr_last encoding: which requester finished (or was drained) most recently
    localparam logic RR_IC  = 1'b0;
    localparam logic RR_PTW = 1'b1;

    state_t            state_q, state_d;
    logic [XLEN-1:0]   addr_q, addr_d;
    logic              rr_last_q, rr_last_d;
    logic              ic_valid;

    // A killed fetch is not a real request, even in the cycle it is raised
    assign ic_valid = ic_req_i & ~ic_kill_i;

    // State, captured address and round-robin pointer registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            rr_last_q <= RR_PTW;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            rr_last_q <= rr_last_d;
        end
    end

    // Arbitration, completion and kill handling
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rr_last_d = rr_last_q;
        ic_ack_o  = 1'b0;
        ptw_ack_o = 1'b0;
        case (state_q)
            IDLE: begin
                // Memory acks arriving here belong to abandoned transfers and are dropped
                if (ic_valid && (!ptw_req_i || rr_last_q == RR_PTW)) begin
                    state_d = SERVE_IC;
                    addr_d  = ic_addr_i;
                end else if (ptw_req_i) begin
                    state_d = SERVE_PTW;
                    addr_d  = ptw_addr_i;
                end
            end
            SERVE_IC: begin
                if (ic_kill_i) begin
                    // Kill beats a coincident ack: the data is never delivered
                    if (mem_ack_i) begin
                        state_d   = IDLE;
                        rr_last_d = RR_IC;
                    end else begin
                        state_d = DRAIN;
                    end
                end else if (mem_ack_i) begin
                    ic_ack_o  = 1'b1;
                    state_d   = IDLE;
                    rr_last_d = RR_IC;
                end
            end
            SERVE_PTW: begin
                if (mem_ack_i) begin
                    ptw_ack_o = 1'b1;
                    state_d   = IDLE;
                    rr_last_d = RR_PTW;
                end
            end
            DRAIN: begin
                // Keep the memory request stable until the orphaned access finishes
                if (mem_ack_i) begin
                    state_d   = IDLE;
                    rr_last_d = RR_IC;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign ic_rdata_o  = ic_ack_o  ? mem_rdata_i : '0;
    assign ptw_rdata_o = ptw_ack_o ? mem_rdata_i : '0;
    assign mem_req_o   = (state_q != IDLE);
    assign busy_o      = (state_q != IDLE);
    assign mem_addr_o  = addr_q;

endmodule
